// File: rtl/usr_burst_shift.sv
// Universal WIDTH-bit shift register with a counted burst engine.
// Ports: clk, reset, en, mode, in, msb, lsb, start, count -> out, so_right, so_left, busy, done.
module usr_burst_shift #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             msb,
  input  logic             lsb,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] out,
  output logic             so_right,
  output logic             so_left,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [CW-1:0]    rem_q;
  logic [2:0]       bmode_q;
  logic [2:0]       sel_mode;
  logic             busy_q;
  logic             done_q;

  // A burst replays its latched mode; otherwise the live mode applies.
  assign sel_mode = (state_q == RUN) ? bmode_q : mode;

  always_comb begin
    out_d = out_q;
    unique case (sel_mode)
      3'b000: out_d = out_q;
      3'b001: out_d = {msb, out_q[WIDTH-1:1]};
      3'b010: out_d = {out_q[WIDTH-2:0], lsb};
      3'b011: out_d = in;
      3'b100: out_d = {out_q[0], out_q[WIDTH-1:1]};
      3'b101: out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      3'b110: out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
      3'b111: out_d = '0;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      bmode_q <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bmode_q <= mode;
            rem_q   <= count;
            if (count != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end else if (en) begin
            out_q <= out_d;
          end
        end
        RUN: begin
          if (en) begin
            out_q <= out_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == {{(CW-1){1'b0}}, 1'b1}) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign so_right = out_q[0];
  assign so_left  = out_q[WIDTH-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_usr_burst_shift.sv
// Directed bench for usr_burst_shift (WIDTH=8 main, WIDTH=4 legacy).
// Inputs change #1 after posedge; outputs checked there.
module tb_usr_burst_shift;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] in = 8'h00;
  logic       msb = 1'b0;
  logic       lsb = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic [7:0] out;
  logic       so_right, so_left, busy, done;

  logic [2:0] mode4 = 3'b000;
  logic [3:0] in4 = 4'h0;
  logic [3:0] out4;
  logic       sr4, sl4, busy4, done4;

  int total = 0;
  int bad = 0;
  int busy_cycles;

  always #5 clk = ~clk;

  usr_burst_shift #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .in(in),
    .msb(msb), .lsb(lsb), .start(start), .count(count),
    .out(out), .so_right(so_right), .so_left(so_left),
    .busy(busy), .done(done)
  );

  usr_burst_shift #(.WIDTH(4), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode4), .in(in4),
    .msb(msb), .lsb(lsb), .start(1'b0), .count(4'd0),
    .out(out4), .so_right(sr4), .so_left(sl4),
    .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    mode = 3'b011;
    in = v;
    en = 1'b1;
    tick();
  endtask

  logic [3:0] exp_r [4];
  logic [3:0] exp_l [4];

  initial begin
    exp_r[0] = 4'h8; exp_r[1] = 4'hC; exp_r[2] = 4'hE; exp_r[3] = 4'hF;
    exp_l[0] = 4'h1; exp_l[1] = 4'h3; exp_l[2] = 4'h7; exp_l[3] = 4'hF;

    repeat (3) tick();
    chk("rst_out", out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;

    load8(8'hA5);
    chk("load_a5", out, 8'hA5);
    chk("sl_a5", so_left, 1'b1);

    load8(8'h80);
    mode = 3'b110;
    msb = 1'b0;
    tick(); chk("asr1", out, 8'hC0);
    tick(); chk("asr2", out, 8'hE0);
    tick(); chk("asr3", out, 8'hF0);
    mode = 3'b001;
    tick(); chk("lsr", out, 8'h78);

    // rotate-right burst of 3 from 0x81
    load8(8'h81);
    mode = 3'b100; count = 4'd3; start = 1'b1;
    tick();
    chk("rr_e0_busy", busy, 1'b1);
    chk("rr_e0_out", out, 8'h81);
    chk("rr_e0_done", done, 1'b0);
    start = 1'b0; mode = 3'b111; count = 4'd9;
    tick();
    chk("rr_e1", out, 8'hC0);
    chk("rr_e1_sr", so_right, 1'b0);
    chk("rr_e1_busy", busy, 1'b1);
    tick();
    chk("rr_e2", out, 8'h60);
    chk("rr_e2_sr", so_right, 1'b0);
    tick();
    chk("rr_e3", out, 8'h30);
    chk("rr_e3_busy", busy, 1'b0);
    chk("rr_e3_done", done, 1'b1);
    mode = 3'b000;
    tick();
    chk("rr_done_low", done, 1'b0);
    chk("rr_hold", out, 8'h30);

    // left-shift burst of 4 with two stalls and an ignored start
    load8(8'h00);
    mode = 3'b010; lsb = 1'b1; count = 4'd4; start = 1'b1;
    busy_cycles = 0;
    tick(); if (busy) busy_cycles++;
    start = 1'b0;
    tick(); if (busy) busy_cycles++;
    chk("sl_s1", out, 8'h01);
    en = 1'b0; start = 1'b1; mode = 3'b111; count = 4'd1;
    tick(); if (busy) busy_cycles++;
    tick(); if (busy) busy_cycles++;
    chk("sl_stall", out, 8'h01);
    en = 1'b1; start = 1'b0; mode = 3'b000;
    tick(); if (busy) busy_cycles++;
    chk("sl_s2", out, 8'h03);
    tick(); if (busy) busy_cycles++;
    tick(); if (busy) busy_cycles++;
    chk("sl_final", out, 8'h0F);
    chk("sl_done", done, 1'b1);
    chk("sl_busycnt", busy_cycles, 6);

    // zero-length burst
    start = 1'b1; count = 4'd0; mode = 3'b011; in = 8'hFF;
    tick();
    chk("z_busy", busy, 1'b0);
    chk("z_done", done, 1'b1);
    chk("z_out", out, 8'h0F);
    start = 1'b0; mode = 3'b000;
    tick();
    chk("z_done_low", done, 1'b0);

    // long burst aborted by reset at step 7
    start = 1'b1; count = 4'd15; mode = 3'b010; lsb = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    repeat (6) tick();
    chk("ab_s6", out, 8'hFF);
    chk("ab_busy6", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_out", out, 8'h00);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    tick();
    chk("ab_done2", done, 1'b0);
    chk("ab_out2", out, 8'h00);

    // legacy WIDTH=4
    in4 = 4'hF; msb = 1'b1; lsb = 1'b1; en = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    mode4 = 3'b000;
    tick(); chk("w4_hold", out4, 4'h0);
    mode4 = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("w4_r%0d", i), out4, exp_r[i]);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    mode4 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("w4_l%0d", i), out4, exp_l[i]);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    mode4 = 3'b011;
    tick(); chk("w4_load", out4, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
